// File: rtl/level_scheduler.sv
// Game-run sequencer for the fall-rate tick counter: run/pause/over FSM, level and
// line bookkeeping, speed select, counter-restart strobe and one-cycle drop step.
// Optional soft-drop speed override is compiled in with SOFT_DROP_EN.
module level_scheduler #(
  parameter int LINES_PER_LEVEL = 4,
  parameter int LEVEL_MAX       = 9,
  parameter int LEVEL_W         = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               start,
  input  logic               pause,
  input  logic               line_clr,
  input  logic               game_over,
  input  logic               tick,
`ifdef SOFT_DROP_EN
  input  logic               soft_drop,
`endif
  output logic [1:0]         speed,
  output logic               tick_rst,
  output logic               step,
  output logic [LEVEL_W-1:0] level,
  output logic [1:0]         state
);

  localparam int CNT_W = $clog2(LINES_PER_LEVEL) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LINES_PER_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(LEVEL_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   line_cnt, cnt_d;
  logic [LEVEL_W-1:0] level_d;
  logic [1:0]         speed_d;
  logic               tick_rst_d, step_d, soft_force;

  // Levels 0..2 map straight onto the speed select; everything above runs flat out.
  function automatic logic [1:0] level_speed(input logic [LEVEL_W-1:0] l);
    return (l >= LEVEL_W'(3)) ? 2'b11 : l[1:0];
  endfunction

  assign state = state_q;

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; game_over outranks pause, start only counts from IDLE/OVER.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (game_over) state_d = OVER;
               else if (pause) state_d = PAUSE;
      PAUSE:   if (game_over) state_d = OVER;
               else if (pause) state_d = RUN;
      OVER:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the line counter.
  always_comb begin
    level_d    = level;
    cnt_d      = line_cnt;
    soft_force = 1'b0;
`ifdef SOFT_DROP_EN
    soft_force = soft_drop;
`endif
    if ((state_q == IDLE || state_q == OVER) && start) begin
      level_d = '0;
      cnt_d   = '0;
    end else if (state_q == RUN && !game_over && !pause && line_clr) begin
      if (line_cnt == CNT_LAST) begin
        // Count wraps even when the level is already saturated.
        cnt_d = '0;
        if (level != LVL_MAX) level_d = level + LEVEL_W'(1);
      end else begin
        cnt_d = line_cnt + CNT_W'(1);
      end
    end
    speed_d = (soft_force && state_d == RUN) ? 2'b11 : level_speed(level_d);
    // Hold the counter cleared outside RUN, on the first RUN cycle, and on any rate change.
    tick_rst_d = !(state_q == RUN && state_d == RUN) || (speed_d != speed);
    // Ticks arriving while the counter is being restarted are stale and dropped.
    step_d = (state_q == RUN) && tick && !tick_rst;
  end

  // Output and bookkeeping registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      level    <= '0;
      line_cnt <= '0;
      speed    <= 2'b00;
      tick_rst <= 1'b1;
      step     <= 1'b0;
    end else begin
      level    <= level_d;
      line_cnt <= cnt_d;
      speed    <= speed_d;
      tick_rst <= tick_rst_d;
      step     <= step_d;
    end
  end

endmodule

// File: tb/tb_level_scheduler.sv
// Directed bench for level_scheduler: reset, start, step latency, level/speed
// progression and saturation, pause/over handling, mid-game reset, soft drop.
module tb_level_scheduler;
  logic       Clock = 1'b0;
  logic       Reset, start, pause, line_clr, game_over, tick;
  logic       soft_drop;
  logic [1:0] speed, state;
  logic       tick_rst, step;
  logic [3:0] level;
  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  level_scheduler #(.LINES_PER_LEVEL(4), .LEVEL_MAX(9), .LEVEL_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .pause(pause),
    .line_clr(line_clr), .game_over(game_over), .tick(tick),
`ifdef SOFT_DROP_EN
    .soft_drop(soft_drop),
`endif
    .speed(speed), .tick_rst(tick_rst), .step(step), .level(level), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_clr(input int n);
    for (int i = 0; i < n; i++) begin
      line_clr = 1'b1;
      cyc();
    end
    line_clr = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; pause = 1'b0; line_clr = 1'b0;
    game_over = 1'b0; tick = 1'b0; soft_drop = 1'b0;
    cyc(); cyc();
    check("rst_state", state, 2'b00);
    check("rst_level", level, 4'd0);
    check("rst_speed", speed, 2'b00);
    check("rst_step", step, 1'b0);
    check("rst_tick_rst", tick_rst, 1'b1);

    Reset = 1'b0; tick = 1'b1; cyc(); tick = 1'b0;
    check("idle_state", state, 2'b00);
    check("idle_no_step", step, 1'b0);

    start = 1'b1; cyc(); start = 1'b0;
    check("start_state", state, 2'b01);
    check("start_tick_rst", tick_rst, 1'b1);
    check("start_speed", speed, 2'b00);
    cyc();
    check("run_tick_rst_low", tick_rst, 1'b0);

    tick = 1'b1; cyc(); tick = 1'b0;
    check("step_after_tick", step, 1'b1);
    cyc();
    check("step_one_cycle", step, 1'b0);

    pulse_clr(3);
    check("lvl_after3", level, 4'd0);
    check("tick_rst_after3", tick_rst, 1'b0);
    pulse_clr(1);
    check("lvl_after4", level, 4'd1);
    check("speed_after4", speed, 2'b01);
    check("tick_rst_lvlup", tick_rst, 1'b1);
    cyc();
    check("tick_rst_lvlup_end", tick_rst, 1'b0);

    pulse_clr(8);
    check("lvl_after12", level, 4'd3);
    check("speed_after12", speed, 2'b11);
    pulse_clr(40);
    check("lvl_saturated", level, 4'd9);
    check("speed_saturated", speed, 2'b11);
    check("tick_rst_no_speed_chg", tick_rst, 1'b0);

    pause = 1'b1; cyc(); pause = 1'b0;
    check("pause_state", state, 2'b10);
    check("pause_tick_rst", tick_rst, 1'b1);
    tick = 1'b1; cyc(); tick = 1'b0;
    check("pause_no_step", step, 1'b0);
    line_clr = 1'b1; cyc(); line_clr = 1'b0;
    check("pause_level_frozen", level, 4'd9);
    check("pause_tick_rst_held", tick_rst, 1'b1);

    pause = 1'b1; cyc(); pause = 1'b0;
    check("resume_state", state, 2'b01);
    check("resume_tick_rst", tick_rst, 1'b1);
    tick = 1'b1; cyc(); tick = 1'b0;
    check("resume_tick_rst_end", tick_rst, 1'b0);
    check("resume_tick_discarded", step, 1'b0);
    tick = 1'b1; cyc(); tick = 1'b0;
    check("resume_step", step, 1'b1);

    pause = 1'b1; line_clr = 1'b1; game_over = 1'b1; cyc();
    pause = 1'b0; line_clr = 1'b0; game_over = 1'b0;
    check("over_state", state, 2'b11);
    check("over_level", level, 4'd9);
    check("over_tick_rst", tick_rst, 1'b1);
    pause = 1'b1; cyc(); pause = 1'b0;
    check("over_ignores_pause", state, 2'b11);

    start = 1'b1; cyc(); start = 1'b0;
    check("restart_state", state, 2'b01);
    check("restart_level", level, 4'd0);
    check("restart_speed", speed, 2'b00);
    check("restart_tick_rst", tick_rst, 1'b1);
    cyc();

`ifdef SOFT_DROP_EN
    soft_drop = 1'b1; cyc();
    check("soft_press_speed", speed, 2'b11);
    check("soft_press_tick_rst", tick_rst, 1'b1);
    cyc();
    check("soft_hold_tick_rst", tick_rst, 1'b0);
    soft_drop = 1'b0; cyc();
    check("soft_release_speed", speed, 2'b00);
    check("soft_release_tick_rst", tick_rst, 1'b1);
    check("soft_level", level, 4'd0);
    cyc();
`endif

    tick = 1'b1; cyc(); tick = 1'b0;
    check("pre_reset_step", step, 1'b1);
    tick = 1'b1; Reset = 1'b1; cyc(); tick = 1'b0;
    check("midrst_step", step, 1'b0);
    check("midrst_state", state, 2'b00);
    check("midrst_tick_rst", tick_rst, 1'b1);
    check("midrst_level", level, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/level_scheduler.md
Name: level_scheduler

Overview:
- Sequences the game's fall-rate tick counter.
- Owns the game-run state machine and the level/line bookkeeping, and drives the 2-bit speed select and a counter-restart strobe into the tick counter.
- Gates the counter's tick into a one-cycle step enable for the piece-drop logic.
- Sits between the input debouncers/game logic and the tick counter.

Parameters:
- LINES_PER_LEVEL, 4: line-clear events needed to advance one level (≥1).
- LEVEL_MAX, 9: saturation value of level.
- LEVEL_W, 4: level width; must hold LEVEL_MAX.

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begin new game
- pause  in  1  one-cycle pulse; toggle pause
- line_clr  in  1  one-cycle pulse; one line cleared
- game_over  in  1  one-cycle pulse from game logic
- tick  in  1  tick from tick counter
- speed  out  2  speed select to tick counter
- tick_rst  out  1  drives tick counter Reset
- step  out  1  one-cycle drop enable to game logic
- level  out  LEVEL_W  current level
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
- soft_drop  in  1  held level; present only with SOFT_DROP_EN

Behaviour:
- All outputs registered.
- Reset values: state=IDLE, level=0, internal line count=0, speed=00, step=0, tick_rst=1.
- tick_rst is 1 in IDLE, PAUSE and OVER, which holds the counter cleared. In RUN it is 0 except for the one-cycle restart pulses below.
- speed = 2'b11 when level ≥ 3, otherwise level[1:0]. Updated the same cycle level updates.
- step=1 exactly one cycle after a cycle with state=RUN, tick=1 and tick_rst=0. Latency is 1 clock; otherwise step=0.
- Priority when events coincide: game_over > pause > line_clr. start is only acted on in IDLE or OVER.
- IDLE:
  - start → RUN; level=0, line count=0, speed=00.
  - tick_rst is 1 on the transition cycle and drops to 0 the cycle after.
- RUN:
  - game_over → OVER.
  - Else pause → PAUSE.
  - Else line_clr increments line count. When the count equals LINES_PER_LEVEL−1, it wraps to 0 and level increments, saturating at LEVEL_MAX (the count still wraps at saturation).
  - Any change of speed causes a one-cycle tick_rst=1 in the same cycle, so the counter restarts its period at the new rate.
  - A tick seen in a cycle with tick_rst=1 is discarded and produces no step.
- PAUSE:
  - pause → RUN with one-cycle tick_rst pulse; game_over → OVER.
  - line_clr and start are ignored; level and line count are frozen; step=0.
- OVER:
  - step=0; level is held for display.
  - start → RUN with the same clearing as from IDLE.
  - pause and line_clr are ignored.
- Reset asserted mid-game:
  - Next edge returns everything to reset values.
  - A step pending from a tick in the prior cycle is cancelled (step=0).
- Line count width is $clog2(LINES_PER_LEVEL)+1.

Optional Feature:
- Macro: SOFT_DROP_EN.
- Defined:
  - soft_drop port exists. While soft_drop=1 in RUN, speed is forced to 2'b11 regardless of level.
  - Each transition of the effective speed (press or release) generates the one-cycle tick_rst pulse.
  - level and line accounting are unaffected.
- Not defined: port absent; speed follows level only.

Test Plan:
- Reset, then start pulse → state=01 next cycle, tick_rst=1 for 1 cycle then 0, speed=00, level=0.
- RUN, tick=1 at cycle N → step=1 at cycle N+1 only; tick while state=10 → step stays 0.
- 4 line_clr pulses (LINES_PER_LEVEL=4) → level 0→1, speed=01, one tick_rst pulse on the 4th. 12 total pulses → level=3, speed=11. 40 more → level saturates at 9, speed stays 11.
- pause, line_clr and game_over in the same cycle from RUN → state=11, level unchanged. A following start → state=01, level=0.
- pause pulse → state=10, tick_rst held 1. Second pause → state=01, single-cycle tick_rst pulse. A tick coincident with that pulse gives no step.
- SOFT_DROP_EN, level=0: soft_drop rises → speed=11 with tick_rst pulse; soft_drop falls → speed=00 with tick_rst pulse.
